// File: rtl/pe_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_cmd_pkg
// Description : Command codes and FSM state type shared by the systolic
//               processing node and its multiplier pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_cmd_pkg;

    // Command codes (low four bits of the command field)
    localparam logic [3:0] CMD_NOP       = 4'd0;
    localparam logic [3:0] CMD_MUL       = 4'd1;
    localparam logic [3:0] CMD_MAC       = 4'd2;
    localparam logic [3:0] CMD_SHIFT_A_U = 4'd3;
    localparam logic [3:0] CMD_SHIFT_A_D = 4'd4;
    localparam logic [3:0] CMD_SHIFT_A_L = 4'd5;
    localparam logic [3:0] CMD_SHIFT_A_R = 4'd6;
    localparam logic [3:0] CMD_SHIFT_B_U = 4'd7;
    localparam logic [3:0] CMD_SHIFT_B_D = 4'd8;
    localparam logic [3:0] CMD_SHIFT_B_L = 4'd9;
    localparam logic [3:0] CMD_SHIFT_B_R = 4'd10;
    localparam logic [3:0] CMD_LOAD_A    = 4'd11;
    localparam logic [3:0] CMD_LOAD_B    = 4'd12;
    localparam logic [3:0] CMD_LOAD_S    = 4'd13;
    localparam logic [3:0] CMD_CLEAR     = 4'd14;

    // Node sequencing states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage : pe_cmd_pkg
`default_nettype wire

// File: rtl/pe_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : pe_mul_pipe
// Description : Signed PRECISION x PRECISION multiplier with MUL_LATENCY
//               register stages and a travelling valid bit.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_mul_pipe #(
    parameter int PRECISION   = 8,
    parameter int MUL_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [PRECISION-1:0]     i_a,
    input  logic [PRECISION-1:0]     i_b,
    output logic                     o_valid,
    output logic [2*PRECISION-1:0]   o_prod
);

    localparam int PW = 2 * PRECISION;

    logic signed [PW-1:0]                w_a_ext;
    logic signed [PW-1:0]                w_b_ext;
    logic [MUL_LATENCY-1:0][PW-1:0]      prod_d;
    logic [MUL_LATENCY-1:0][PW-1:0]      prod_q;
    logic [MUL_LATENCY-1:0]              vld_d;
    logic [MUL_LATENCY-1:0]              vld_q;

    // Sign-extend operands so the full-width product is exact
    assign w_a_ext = PW'($signed(i_a));
    assign w_b_ext = PW'($signed(i_b));

    // Stage 0 computes the product; later stages simply delay it
    always_comb begin
        prod_d    = prod_q;
        vld_d     = vld_q;
        prod_d[0] = w_a_ext * w_b_ext;
        vld_d[0]  = i_valid;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            prod_d[i] = prod_q[i-1];
            vld_d[i]  = vld_q[i-1];
        end
    end

    // Pipeline registers; reset flushes any in-flight product
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            vld_q  <= '0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
        end
    end

    assign o_valid = vld_q[MUL_LATENCY-1];
    assign o_prod  = prod_q[MUL_LATENCY-1];

endmodule : pe_mul_pipe
`default_nettype wire

// File: rtl/pe_cmd_node.sv
`default_nettype none
// ============================================================================
// Module      : pe_cmd_node
// Description : Systolic-array processing node with valid/ready command
//               handshake, pipelined signed multiply / multiply-accumulate,
//               neighbour A/B shifting and reserved-code error pulses.
//               Optional macro PE_MAC_SATURATE_EN: MAC saturates to the
//               signed accumulator range and sets a sticky sat_flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_cmd_node
    import pe_cmd_pkg::*;
#(
    parameter int PRECISION        = 8,
    parameter int OUTPUT_PRECISION = 32,
    parameter int CMD_WIDTH        = 4,
    parameter int MUL_LATENCY      = 2
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [CMD_WIDTH-1:0]        cmd,
    output logic                        done,
    output logic                        cmd_err,
    input  logic [PRECISION-1:0]        isu_a,
    input  logic [PRECISION-1:0]        isd_a,
    input  logic [PRECISION-1:0]        isl_a,
    input  logic [PRECISION-1:0]        isr_a,
    input  logic [PRECISION-1:0]        isu_b,
    input  logic [PRECISION-1:0]        isd_b,
    input  logic [PRECISION-1:0]        isl_b,
    input  logic [PRECISION-1:0]        isr_b,
    input  logic [PRECISION-1:0]        a_overwrite,
    input  logic [PRECISION-1:0]        b_overwrite,
    input  logic [OUTPUT_PRECISION-1:0] s_overwrite,
    output logic [PRECISION-1:0]        a_out,
    output logic [PRECISION-1:0]        b_out,
    output logic [OUTPUT_PRECISION-1:0] s_out,
    output logic                        sat_flag
);

    localparam int OP    = OUTPUT_PRECISION;
    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    // Parameter legality checks at elaboration
    if (OUTPUT_PRECISION < 2 * PRECISION) begin : g_bad_output_precision
        $error("pe_cmd_node: OUTPUT_PRECISION must be >= 2*PRECISION");
    end
    if (CMD_WIDTH < 4) begin : g_bad_cmd_width
        $error("pe_cmd_node: CMD_WIDTH must be >= 4");
    end
    if (MUL_LATENCY < 1) begin : g_bad_mul_latency
        $error("pe_cmd_node: MUL_LATENCY must be >= 1");
    end

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PRECISION-1:0]   a_q, a_d;
    logic [PRECISION-1:0]   b_q, b_d;
    logic [OP-1:0]          s_q, s_d;
    logic [OP-1:0]          base_q, base_d;
    logic                   mac_q, mac_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   sat_q, sat_d;

    logic                   w_mul_start;
    logic                   w_mul_valid;
    logic [2*PRECISION-1:0] w_prod;
    logic [OP-1:0]          w_prod_ext;
    logic [OP-1:0]          w_sum;
    logic [3:0]             w_code;
    logic                   w_code_hi;

    // Any set bit above the four defined code bits marks a reserved command
    if (CMD_WIDTH > 4) begin : g_cmd_hi
        assign w_code_hi = |cmd[CMD_WIDTH-1:4];
    end else begin : g_cmd_no_hi
        assign w_code_hi = 1'b0;
    end
    assign w_code = cmd[3:0];

    pe_mul_pipe #(
        .PRECISION   (PRECISION),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul_pipe (
        .clk     (CLK),
        .rst     (reset),
        .i_valid (w_mul_start),
        .i_a     (a_q),
        .i_b     (b_q),
        .o_valid (w_mul_valid),
        .o_prod  (w_prod)
    );

    assign w_prod_ext = OP'($signed(w_prod));
    assign w_sum      = base_q + w_prod_ext;

    // Command decode, register updates and multiply sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        base_d      = base_q;
        mac_d       = mac_q;
        sat_d       = sat_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        w_mul_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    done_d = 1'b1;
                    if (w_code_hi) begin
                        err_d = 1'b1;
                    end else begin
                        case (w_code)
                            CMD_NOP: ;
                            CMD_MUL, CMD_MAC: begin
                                // Operands and accumulator base are frozen now;
                                // done is reported when the product returns
                                done_d      = 1'b0;
                                state_d     = ST_BUSY;
                                cnt_d       = CNT_W'(MUL_LATENCY - 1);
                                base_d      = s_q;
                                mac_d       = (w_code == CMD_MAC);
                                w_mul_start = 1'b1;
                            end
                            CMD_SHIFT_A_U: a_d = isu_a;
                            CMD_SHIFT_A_D: a_d = isd_a;
                            CMD_SHIFT_A_L: a_d = isl_a;
                            CMD_SHIFT_A_R: a_d = isr_a;
                            CMD_SHIFT_B_U: b_d = isu_b;
                            CMD_SHIFT_B_D: b_d = isd_b;
                            CMD_SHIFT_B_L: b_d = isl_b;
                            CMD_SHIFT_B_R: b_d = isr_b;
                            CMD_LOAD_A:    a_d = a_overwrite;
                            CMD_LOAD_B:    b_d = b_overwrite;
                            CMD_LOAD_S:    s_d = s_overwrite;
                            CMD_CLEAR: begin
                                a_d   = '0;
                                b_d   = '0;
                                s_d   = '0;
                                sat_d = 1'b0;
                            end
                            default:       err_d = 1'b1;
                        endcase
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (w_mul_valid) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (!mac_q) begin
                        s_d = w_prod_ext;
                    end else begin
`ifdef PE_MAC_SATURATE_EN
                        // Signed overflow: same-sign operands, different-sign sum
                        if ((base_q[OP-1] == w_prod_ext[OP-1]) &&
                            (w_sum[OP-1] != base_q[OP-1])) begin
                            s_d   = base_q[OP-1] ? {1'b1, {(OP-1){1'b0}}}
                                                 : {1'b0, {(OP-1){1'b1}}};
                            sat_d = 1'b1;
                        end else begin
                            s_d = w_sum;
                        end
`else
                        s_d = w_sum;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset wins over everything, including an active multiply
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            base_q  <= '0;
            mac_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            base_q  <= base_d;
            mac_q   <= mac_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sat_q   <= sat_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign done      = done_q;
    assign cmd_err   = err_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign s_out     = s_q;
`ifdef PE_MAC_SATURATE_EN
    assign sat_flag  = sat_q;
`else
    assign sat_flag  = 1'b0;
`endif

endmodule : pe_cmd_node
`default_nettype wire

// File: tb/tb_pe_cmd_node.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_cmd_node
// Description : Directed self-checking bench for pe_cmd_node
//               (PRECISION=8, OUTPUT_PRECISION=32, CMD_WIDTH=4, MUL_LATENCY=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_cmd_node;

    logic        CLK = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd;
    logic        done;
    logic        cmd_err;
    logic [7:0]  isu_a, isd_a, isl_a, isr_a;
    logic [7:0]  isu_b, isd_b, isl_b, isr_b;
    logic [7:0]  a_overwrite, b_overwrite;
    logic [31:0] s_overwrite;
    logic [7:0]  a_out, b_out;
    logic [31:0] s_out;
    logic        sat_flag;

    int n_vec  = 0;
    int n_fail = 0;

    pe_cmd_node #(
        .PRECISION        (8),
        .OUTPUT_PRECISION (32),
        .CMD_WIDTH        (4),
        .MUL_LATENCY      (2)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd         (cmd),
        .done        (done),
        .cmd_err     (cmd_err),
        .isu_a       (isu_a),
        .isd_a       (isd_a),
        .isl_a       (isl_a),
        .isr_a       (isr_a),
        .isu_b       (isu_b),
        .isd_b       (isd_b),
        .isl_b       (isl_b),
        .isr_b       (isr_b),
        .a_overwrite (a_overwrite),
        .b_overwrite (b_overwrite),
        .s_overwrite (s_overwrite),
        .a_out       (a_out),
        .b_out       (b_out),
        .s_out       (s_out),
        .sat_flag    (sat_flag)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one command for a single accept edge
    task automatic issue(input logic [3:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd = 4'd0;
        isu_a = 8'h0; isd_a = 8'h0; isl_a = 8'h0; isr_a = 8'h0;
        isu_b = 8'h0; isd_b = 8'h0; isl_b = 8'h0; isr_b = 8'h0;
        a_overwrite = 8'h0; b_overwrite = 8'h0; s_overwrite = 32'h0;
        tick(); tick();

        // Reset state
        chk("rst_ready_low", {31'b0, cmd_ready}, 32'd0);
        chk("rst_a", {24'b0, a_out}, 32'h0);
        chk("rst_s", s_out, 32'h0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sat", {31'b0, sat_flag}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_ready_high", {31'b0, cmd_ready}, 32'd1);

        // 1: 5 * -3 = -15
        a_overwrite = 8'h05; issue(4'd11);
        chk("load_a", {24'b0, a_out}, 32'h05);
        chk("load_a_done", {31'b0, done}, 32'd1);
        chk("load_a_err", {31'b0, cmd_err}, 32'd0);
        b_overwrite = 8'hFD; issue(4'd12);
        chk("load_b", {24'b0, b_out}, 32'hFD);
        issue(4'd1);
        chk("mul_busy1_ready", {31'b0, cmd_ready}, 32'd0);
        chk("mul_busy1_done", {31'b0, done}, 32'd0);
        tick();
        chk("mul_busy2_ready", {31'b0, cmd_ready}, 32'd0);
        chk("mul_busy2_s", s_out, 32'h0);
        tick();
        chk("mul_s", s_out, 32'hFFFF_FFF1);
        chk("mul_done", {31'b0, done}, 32'd1);
        chk("mul_ready", {31'b0, cmd_ready}, 32'd1);
        tick();
        chk("mul_done_drop", {31'b0, done}, 32'd0);

        // 2: MAC 16 + (-15) = 1
        s_overwrite = 32'h10; issue(4'd13);
        chk("load_s", s_out, 32'h10);
        issue(4'd2); tick(); tick();
        chk("mac_small", s_out, 32'h1);
        chk("mac_done", {31'b0, done}, 32'd1);
        // MAC overflow: 0x7FFFFFFF + 127*127
        s_overwrite = 32'h7FFF_FFFF; issue(4'd13);
        a_overwrite = 8'h7F; issue(4'd11);
        b_overwrite = 8'h7F; issue(4'd12);
        issue(4'd2); tick(); tick();
`ifdef PE_MAC_SATURATE_EN
        chk("mac_ovf_s", s_out, 32'h7FFF_FFFF);
        chk("mac_ovf_sat", {31'b0, sat_flag}, 32'd1);
`else
        chk("mac_ovf_s", s_out, 32'h8000_3F00);
        chk("mac_ovf_sat", {31'b0, sat_flag}, 32'd0);
`endif
        issue(4'd14);
        chk("clear_sat", {31'b0, sat_flag}, 32'd0);
        chk("clear_a", {24'b0, a_out}, 32'h0);
        chk("clear_b", {24'b0, b_out}, 32'h0);
        chk("clear_s", s_out, 32'h0);

        // 3: back-to-back neighbour shifts
        isl_a = 8'h11; isu_b = 8'h22;
        cmd_valid = 1'b1; cmd = 4'd5;
        tick();
        chk("shift_a_l", {24'b0, a_out}, 32'h11);
        chk("shift1_done", {31'b0, done}, 32'd1);
        chk("shift1_ready", {31'b0, cmd_ready}, 32'd1);
        cmd = 4'd7;
        tick();
        cmd_valid = 1'b0;
        chk("shift_b_u", {24'b0, b_out}, 32'h22);
        chk("shift2_done", {31'b0, done}, 32'd1);
        chk("shift2_ready", {31'b0, cmd_ready}, 32'd1);
        tick();
        chk("shift_done_drop", {31'b0, done}, 32'd0);

        // 4: held shift waits out a MUL (5 * 3 = 15)
        a_overwrite = 8'h05; issue(4'd11);
        b_overwrite = 8'h03; issue(4'd12);
        isr_a = 8'h44;
        cmd_valid = 1'b1; cmd = 4'd1;
        tick();
        cmd = 4'd6;
        tick();
        chk("held_a_busy", {24'b0, a_out}, 32'h05);
        chk("held_ready_busy", {31'b0, cmd_ready}, 32'd0);
        tick();
        chk("held_mul_s", s_out, 32'd15);
        chk("held_mul_done", {31'b0, done}, 32'd1);
        chk("held_a_done_cycle", {24'b0, a_out}, 32'h05);
        tick();
        cmd_valid = 1'b0;
        chk("held_a_shifted", {24'b0, a_out}, 32'h44);
        chk("held_shift_done", {31'b0, done}, 32'd1);

        // 5: reset during multiply discards the result
        issue(4'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_a", {24'b0, a_out}, 32'h0);
        chk("mid_rst_b", {24'b0, b_out}, 32'h0);
        chk("mid_rst_s", s_out, 32'h0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, cmd_ready}, 32'd1);
        tick();
        chk("mid_rst_no_done1", {31'b0, done}, 32'd0);
        tick();
        chk("mid_rst_no_done2", {31'b0, done}, 32'd0);
        chk("mid_rst_s_after", s_out, 32'h0);

        // 6: reserved code
        a_overwrite = 8'h09; issue(4'd11);
        s_overwrite = 32'hA5; issue(4'd13);
        chk("load_s_err", {31'b0, cmd_err}, 32'd0);
        issue(4'd15);
        chk("rsv_done", {31'b0, done}, 32'd1);
        chk("rsv_err", {31'b0, cmd_err}, 32'd1);
        chk("rsv_a", {24'b0, a_out}, 32'h09);
        chk("rsv_b", {24'b0, b_out}, 32'h0);
        chk("rsv_s", s_out, 32'hA5);
        tick();
        chk("rsv_err_drop", {31'b0, cmd_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_pe_cmd_node
`default_nettype wire

// File: doc/pe_cmd_node.md
Name: pe_cmd_node

Overview:
Next-generation systolic-array processing node. Replaces the blocking per-cycle command decode with a valid/ready command handshake, a pipelined signed multiplier, and multiply-accumulate. It also adds B-operand shifting and error reporting for illegal commands. One instance per array cell, driven by the array sequencer. Neighbour cells connect through the a_out/b_out and is*_a/is*_b buses.

Parameters:
PRECISION, 8, operand width (A, B, neighbour buses)
OUTPUT_PRECISION, 32, accumulator width; must be >= 2*PRECISION (elaboration error otherwise)
CMD_WIDTH, 4, command field width; must be >= 4
MUL_LATENCY, 2, multiplier pipeline stages; must be >= 1

Ports:
CLK  in  1  clock; all state changes on rising edge
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  node can accept a command
cmd  in  CMD_WIDTH  command code
done  out  1  one-cycle pulse per completed command
cmd_err  out  1  one-cycle pulse, coincident with done, for reserved codes
isu_a, isd_a, isl_a, isr_a  in  PRECISION each  A from up/down/left/right neighbour
isu_b, isd_b, isl_b, isr_b  in  PRECISION each  B from neighbours
a_overwrite, b_overwrite  in  PRECISION  load values
s_overwrite  in  OUTPUT_PRECISION  accumulator load value
a_out, b_out  out  PRECISION  registered A/B, broadcast to all four neighbours
s_out  out  OUTPUT_PRECISION  accumulator
sat_flag  out  1  sticky saturation indicator (see Optional Feature)

Behaviour:
- Reset: A=0, B=0, s_out=0, done=0, cmd_err=0, sat_flag=0, FSM=IDLE, latency counter=0. Reset has priority at every edge, including mid-multiply. The in-flight result is discarded and no done pulse is produced.
- cmd_ready = (state==IDLE) && !reset.
- A command is accepted at a rising edge where cmd_valid && cmd_ready.
- Codes: 0 NOP; 1 MUL s_out<=sext(A*B); 2 MAC s_out<=s_out+sext(A*B); 3/4/5/6 SHIFT_A_U/D/L/R A<=is{u,d,l,r}_a; 7/8/9/10 SHIFT_B_U/D/L/R B<=is*_b; 11 LOAD_A; 12 LOAD_B; 13 LOAD_S; 14 CLEAR (A, B, s_out, sat_flag <= 0); 15 reserved.
- Single-cycle commands (all except 1 and 2): register update at the accept edge; done=1 for the following cycle. cmd_ready stays high, so back-to-back commands are accepted on consecutive cycles.
- MUL/MAC: operands A, B and the s_out base are captured at the accept edge. FSM goes IDLE->BUSY; counter loads MUL_LATENCY-1. s_out is written at edge accept+MUL_LATENCY, FSM returns to IDLE, and done=1 for the next cycle.
- While BUSY, cmd_ready=0 and a held cmd_valid waits. A held command is accepted at the first edge of the done cycle.
- Arithmetic: A and B are signed two's complement. The 2*PRECISION product is sign-extended to OUTPUT_PRECISION. MAC wraps modulo 2^OUTPUT_PRECISION unless the optional feature is compiled in.
- Reserved codes (>=15, and any code above 15 when CMD_WIDTH>4): accepted; no register change; done and cmd_err pulse together.
- a_out=A and b_out=B combinationally from the registers. A shift therefore reads the neighbour's pre-edge value, which gives a clean systolic transfer when every cell shifts on the same edge.

Optional Feature:
Macro PE_MAC_SATURATE_EN.
- Defined: a MAC result that overflows signed OUTPUT_PRECISION clamps to the signed max or min and sets sat_flag. sat_flag is sticky and is cleared only by reset or CLEAR. MUL cannot overflow and is unaffected.
- Not defined: MAC wraps and sat_flag is tied to 0.

Decomposition:
- Shared package pe_cmd_pkg: command code constants and the FSM state typedef (IDLE, BUSY).
- Sub-module pe_mul_pipe: parametrised signed PRECISION x PRECISION multiplier with MUL_LATENCY register stages and a valid-in/valid-out bit; pe_cmd_node instantiates it once.

Test Plan:
1. P=8, OP=32, L=2: LOAD_A 0x05, LOAD_B 0xFD, MUL -> s_out=0xFFFFFFF1 two edges after accept; done one cycle; cmd_ready low for 2 cycles.
2. LOAD_S 0x00000010, A=0x05, B=0xFD, MAC -> s_out=0x00000001. LOAD_S 0x7FFFFFFF, A=B=0x7F, MAC -> 0x80003F00 without the macro; 0x7FFFFFFF and sat_flag=1 with PE_MAC_SATURATE_EN; CLEAR -> sat_flag=0.
3. SHIFT_A_L with isl_a=0x11 then SHIFT_B_U with isu_b=0x22 on consecutive cycles -> A=0x11, B=0x22, done high two consecutive cycles, cmd_ready never low.
4. cmd_valid held with SHIFT_A_R during MUL -> not accepted while BUSY; accepted on the done cycle; A updates one edge later.
5. Reset asserted the cycle after a MUL accept -> no done pulse; A/B/s_out=0; cmd_ready=1 on the first cycle with reset low.
6. cmd=15 -> done and cmd_err pulse together; A, B, s_out unchanged.
